// File: rtl/sort_pkg.sv
// Shared types and constants for the sorter memory responder.
// Response codes and read/write FSM state encodings.
package sort_pkg;

    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 1;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/sort_mem_responder_if.sv
// Read (AR/R) and write (AW/W/B) channel bundle between the sorter
// datapath (master) and the memory responder (slave).
interface sort_mem_responder_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) ();

    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;

    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output ar_valid, ar_address, r_ready,
        output aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_address, r_ready,
        input  aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_resp
    );

endinterface

// File: rtl/sort_mem_array.sv
// Word array with one write port and one synchronous read port.
// A read on the same edge as a write to that word returns the old word.
module sort_mem_array #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_WDTH-1:0] waddr_i,
    input  logic [DATA_WDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_WDTH-1:0] raddr_i,
    output logic [DATA_WDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WDTH;

    logic [DATA_WDTH-1:0] mem_q [DEPTH];
    logic [DATA_WDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sort_mem_responder.sv
// Memory responder for the sorter: independent read and write FSMs
// over a shared word array, with range checking against arr_size.
module sort_mem_responder
    import sort_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_WDTH:0] arr_size,
    sort_mem_responder_if.slave bus
);

    localparam logic [RESP_WDTH-1:0] R_OK  = RESP_WDTH'(RESP_OKAY);
    localparam logic [RESP_WDTH-1:0] R_ERR = RESP_WDTH'(RESP_SLVERR);

    rd_state_t            rd_q;
    logic                 ar_ready_q;
    logic                 r_valid_q;
    logic                 rd_ok_q;
    logic [RESP_WDTH-1:0] r_resp_q;

    wr_state_t            wr_q;
    logic                 aw_ready_q;
    logic                 w_ready_q;
    logic                 b_valid_q;
    logic [RESP_WDTH-1:0] b_resp_q;
    logic                 aw_got_q;
    logic                 w_got_q;
    logic [ADDR_WDTH-1:0] waddr_q;
    logic [DATA_WDTH-1:0] wdata_q;

    logic                 ar_hs;
    logic                 rd_oor;
    logic                 re;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 commit;
    logic [ADDR_WDTH-1:0] waddr_d;
    logic [DATA_WDTH-1:0] wdata_d;
    logic                 wr_oor;
    logic                 we;
    logic [DATA_WDTH-1:0] arr_rdata;

    assign ar_hs  = (rd_q == RD_IDLE) && bus.ar_valid && ar_ready_q;
    assign rd_oor = {1'b0, bus.ar_address} >= arr_size;
    assign re     = ar_hs && !rd_oor;

    // Address/data come from this edge's handshake or the captured copy.
    assign aw_hs   = (wr_q == WR_IDLE) && bus.aw_valid && aw_ready_q;
    assign w_hs    = (wr_q == WR_IDLE) && bus.w_valid && w_ready_q;
    assign waddr_d = aw_hs ? bus.aw_address : waddr_q;
    assign wdata_d = w_hs ? bus.w_data : wdata_q;
    assign commit  = (wr_q == WR_IDLE)
                   && (aw_got_q || aw_hs)
                   && (w_got_q || w_hs);
    assign wr_oor  = {1'b0, waddr_d} >= arr_size;
    assign we      = commit && !wr_oor;

    sort_mem_array #(
        .ADDR_WDTH(ADDR_WDTH),
        .DATA_WDTH(DATA_WDTH)
    ) u_array (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(waddr_d),
        .wdata_i(wdata_d),
        .re_i   (re),
        .raddr_i(bus.ar_address),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= RD_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            rd_ok_q    <= 1'b0;
            r_resp_q   <= R_OK;
        end else begin
            unique case (rd_q)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_q       <= RD_RESP;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        rd_ok_q    <= !rd_oor;
                        r_resp_q   <= rd_oor ? R_ERR : R_OK;
                    end
                end
                RD_RESP: begin
                    if (bus.r_ready) begin
                        rd_q       <= RD_IDLE;
                        ar_ready_q <= 1'b1;
                        r_valid_q  <= 1'b0;
                    end
                end
                default: rd_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= WR_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= R_OK;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (wr_q)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_got_q   <= 1'b1;
                        aw_ready_q <= 1'b0;
                        waddr_q    <= bus.aw_address;
                    end
                    if (w_hs) begin
                        w_got_q   <= 1'b1;
                        w_ready_q <= 1'b0;
                        wdata_q   <= bus.w_data;
                    end
                    if (commit) begin
                        wr_q       <= WR_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_oor ? R_ERR : R_OK;
                    end
                end
                WR_RESP: begin
                    if (bus.b_ready) begin
                        wr_q       <= WR_IDLE;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        b_valid_q  <= 1'b0;
                        aw_got_q   <= 1'b0;
                        w_got_q    <= 1'b0;
                    end
                end
                default: wr_q <= WR_IDLE;
            endcase
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.r_data   = rd_ok_q ? arr_rdata : '0;
    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;

endmodule

// File: tb/tb_sort_mem_responder.sv
// Scoreboard bench for sort_mem_responder: a reference array model
// predicts responses, which are queued and compared on output.
module tb_sort_mem_responder;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   arr_size = '0;

    sort_mem_responder_if #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)
    ) bus ();

    sort_mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arr_size(arr_size),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mdl [16];
    logic [DW:0]   exp_r_q [$];
    logic          exp_b_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic oor(input logic [AW-1:0] a);
        return {1'b0, a} >= arr_size;
    endfunction

    function automatic logic [DW:0] pred_rd(input logic [AW-1:0] a);
        if (oor(a)) return {1'b1, DW'(0)};
        return {1'b0, mdl[a]};
    endfunction

    function automatic void pred_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_b_q.push_back(oor(a));
        if (!oor(a)) mdl[a] = d;
    endfunction

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                      output logic r, output int wt);
        bus.ar_valid = 1'b1;
        bus.ar_address = a;
        wt = 0;
        while (!bus.ar_ready && wt < 20) begin tick(); wt++; end
        exp_r_q.push_back(pred_rd(a));
        tick();
        bus.ar_valid = 1'b0;
        while (!bus.r_valid && wt < 40) begin tick(); wt++; end
        d = bus.r_data;
        r = bus.r_resp;
        bus.r_ready = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic r, output int wt);
        bus.aw_valid = 1'b1;
        bus.aw_address = a;
        bus.w_valid = 1'b1;
        bus.w_data = d;
        wt = 0;
        while (!(bus.aw_ready && bus.w_ready) && wt < 20) begin tick(); wt++; end
        pred_wr(a, d);
        tick();
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b0;
        while (!bus.b_valid && wt < 40) begin tick(); wt++; end
        r = bus.b_resp;
        bus.b_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.ar_valid = 0; bus.ar_address = '0; bus.r_ready = 1;
        bus.aw_valid = 0; bus.aw_address = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.b_ready = 1;
        rst = 1'b1;
        #12;
        n_tests++; if (bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ar_ready got %b want 1", bus.ar_ready); end
        n_tests++; if (bus.aw_ready !== 1'b1) begin n_fail++; $display("FAIL rst_aw_ready got %b want 1", bus.aw_ready); end
        n_tests++; if (bus.w_ready !== 1'b1) begin n_fail++; $display("FAIL rst_w_ready got %b want 1", bus.w_ready); end
        n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r_valid got %b want 0", bus.r_valid); end
        n_tests++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b want 0", bus.b_valid); end
        n_tests++; if (bus.r_data !== '0) begin n_fail++; $display("FAIL rst_r_data got %h want 0", bus.r_data); end
        n_tests++; if (bus.r_resp !== 1'b0 || bus.b_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp got %b/%b want 0/0", bus.r_resp, bus.b_resp); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 8;
        wr(3, 32'hDEADBEEF, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (wt !== 0) begin n_fail++; $display("FAIL basic_b_lat got %0d want 0", wt); end
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL basic_b_resp got %b want %b", r, eb); end
        rd(3, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if (wt !== 0) begin n_fail++; $display("FAIL basic_r_lat got %0d want 0", wt); end
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL basic_r got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
    endtask

    task automatic test_order();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 8;
        bus.w_valid = 1'b1;
        bus.w_data = 32'h11;
        tick();
        bus.w_valid = 1'b0;
        n_tests++; if (bus.w_ready !== 1'b0) begin n_fail++; $display("FAIL order_w_ready got %b want 0", bus.w_ready); end
        n_tests++; if (bus.aw_ready !== 1'b1) begin n_fail++; $display("FAIL order_aw_ready got %b want 1", bus.aw_ready); end
        tick();
        n_tests++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_b got %b want 0", bus.b_valid); end
        bus.aw_valid = 1'b1;
        bus.aw_address = 5;
        pred_wr(5, 32'h11);
        tick();
        bus.aw_valid = 1'b0;
        eb = exp_b_q.pop_front();
        n_tests++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL order_b_valid got %b want 1", bus.b_valid); end
        n_tests++; if (bus.b_resp !== eb) begin n_fail++; $display("FAIL order_b_resp got %b want %b", bus.b_resp, eb); end
        tick();
        rd(5, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e || wt !== 0) begin n_fail++; $display("FAIL order_r got %b/%h wt %0d want %b/%h", r, d, wt, e[DW], e[DW-1:0]); end
    endtask

    task automatic test_oor();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 8;
        wr(6, 32'h99, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL oor_w99 got %b want %b", r, eb); end
        arr_size = 4;
        wr(6, 32'h55, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL oor_w55_resp got %b want %b", r, eb); end
        rd(6, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL oor_rd got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
        arr_size = 8;
        rd(6, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL oor_keep got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
        rd(8, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL oor_edge8 got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
    endtask

    task automatic test_bounds();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 16;
        wr(15, 32'hF00D, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL full_w15 got %b want %b", r, eb); end
        rd(15, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL full_r15 got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
        arr_size = 0;
        wr(0, 32'h1, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL zero_w got %b want %b", r, eb); end
        rd(0, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL zero_r got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
    endtask

    task automatic test_backpressure();
        logic [DW:0] e; logic eb;
        arr_size = 8;
        bus.r_ready = 1'b0;
        bus.ar_valid = 1'b1;
        bus.ar_address = 3;
        exp_r_q.push_back(pred_rd(3));
        tick();
        bus.ar_valid = 1'b0;
        e = exp_r_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({bus.r_valid, bus.ar_ready, bus.r_resp, bus.r_data} !== {2'b10, e}) begin
                n_fail++; $display("FAIL bp_r cyc %0d got v%b rdy%b %b/%h want %b/%h", i, bus.r_valid, bus.ar_ready, bus.r_resp, bus.r_data, e[DW], e[DW-1:0]);
            end
            tick();
        end
        bus.r_ready = 1'b1;
        tick();
        n_tests++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL bp_r_release got v%b rdy%b want 0/1", bus.r_valid, bus.ar_ready); end
        bus.b_ready = 1'b0;
        bus.aw_valid = 1'b1; bus.aw_address = 1;
        bus.w_valid = 1'b1; bus.w_data = 32'h1234;
        pred_wr(1, 32'h1234);
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        eb = exp_b_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({bus.b_valid, bus.aw_ready, bus.w_ready, bus.b_resp} !== {3'b100, eb}) begin
                n_fail++; $display("FAIL bp_b cyc %0d got v%b aw%b w%b r%b want 1/0/0/%b", i, bus.b_valid, bus.aw_ready, bus.w_ready, bus.b_resp, eb);
            end
            tick();
        end
        bus.b_ready = 1'b1;
        tick();
        n_tests++; if ({bus.b_valid, bus.aw_ready, bus.w_ready} !== 3'b011) begin n_fail++; $display("FAIL bp_b_release got %b want 011", {bus.b_valid, bus.aw_ready, bus.w_ready}); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 8;
        wr(2, 32'hA, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL col_pre got %b want %b", r, eb); end
        bus.ar_valid = 1'b1; bus.ar_address = 2;
        bus.aw_valid = 1'b1; bus.aw_address = 2;
        bus.w_valid = 1'b1; bus.w_data = 32'hB;
        exp_r_q.push_back(pred_rd(2));
        pred_wr(2, 32'hB);
        tick();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        e = exp_r_q.pop_front();
        eb = exp_b_q.pop_front();
        n_tests++; if ({bus.r_valid, bus.r_resp, bus.r_data} !== {1'b1, e}) begin n_fail++; $display("FAIL col_rd got v%b %b/%h want %b/%h", bus.r_valid, bus.r_resp, bus.r_data, e[DW], e[DW-1:0]); end
        n_tests++; if ({bus.b_valid, bus.b_resp} !== {1'b1, eb}) begin n_fail++; $display("FAIL col_b got %b/%b want 1/%b", bus.b_valid, bus.b_resp, eb); end
        tick();
        rd(2, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL col_after got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d; logic r; int wt; logic [DW:0] e; logic eb;
        arr_size = 8;
        wr(4, 32'h44, r, wt);
        eb = exp_b_q.pop_front();
        n_tests++; if (r !== eb) begin n_fail++; $display("FAIL rm_pre got %b want %b", r, eb); end
        bus.r_ready = 1'b0;
        bus.ar_valid = 1'b1; bus.ar_address = 4;
        bus.aw_valid = 1'b1; bus.aw_address = 4;
        tick();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
        n_tests++; if ({bus.r_valid, bus.aw_ready, bus.w_ready} !== 3'b101) begin n_fail++; $display("FAIL rm_setup got %b want 101", {bus.r_valid, bus.aw_ready, bus.w_ready}); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({bus.r_valid, bus.b_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_valids got %b want 00", {bus.r_valid, bus.b_valid}); end
        n_tests++; if ({bus.ar_ready, bus.aw_ready, bus.w_ready} !== 3'b111) begin n_fail++; $display("FAIL rm_readys got %b want 111", {bus.ar_ready, bus.aw_ready, bus.w_ready}); end
        n_tests++; if (bus.r_data !== '0) begin n_fail++; $display("FAIL rm_r_data got %h want 0", bus.r_data); end
        @(negedge clk);
        rst = 1'b0;
        bus.r_ready = 1'b1;
        tick();
        bus.w_valid = 1'b1; bus.w_data = 32'h77;
        tick();
        bus.w_valid = 1'b0;
        tick();
        n_tests++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL rm_w_alone got b_valid %b want 0", bus.b_valid); end
        bus.aw_valid = 1'b1; bus.aw_address = 7;
        pred_wr(7, 32'h77);
        tick();
        bus.aw_valid = 1'b0;
        eb = exp_b_q.pop_front();
        n_tests++; if ({bus.b_valid, bus.b_resp} !== {1'b1, eb}) begin n_fail++; $display("FAIL rm_b got %b/%b want 1/%b", bus.b_valid, bus.b_resp, eb); end
        tick();
        rd(4, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL rm_addr4 got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
        rd(7, d, r, wt);
        e = exp_r_q.pop_front();
        n_tests++; if ({r, d} !== e) begin n_fail++; $display("FAIL rm_addr7 got %b/%h want %b/%h", r, d, e[DW], e[DW-1:0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_oor();
        test_bounds();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
